sort4_pipe: RTL and testbench

Upstream feeder of the 4-to-8 / 8-to-16 merge network. Collects a serial stream of unsigned WIDTH-bit keys into groups of four and sorts each group ascending through a 3-stage pipelined compare-exchange network. Each sorted group is presented as one 4-element vector with a valid pulse, so the merge stages always receive pre-sorted quadruples.

---
 rtl/sorter_pkg.sv | 11 +
 rtl/sort4_pipe_if.sv | 24 ++
 rtl/sort4_pipe_cmp_swap.sv | 21 ++
 rtl/sort4_pipe.sv | 95 +++++++++
 tb/tb_sort4_pipe.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/sorter_pkg.sv
// Shared constants and types for the sort4_pipe quadruple sorter.
package sorter_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int NUM_GROUP = 4;
    localparam int CNT_W     = 3;
    localparam logic [DEF_WIDTH-1:0] PAD = {DEF_WIDTH{1'b1}};

    typedef logic [CNT_W-1:0] count_t;

endpackage

// File: rtl/sort4_pipe_if.sv
// Key stream in, sorted quadruple out.
// Handshake: in_valid marks a key that is always taken (no ready); out_valid is a
// one-cycle pulse qualifying out_keys/out_count, which hold between pulses.
interface sort4_pipe_if #(parameter int WIDTH = sorter_pkg::DEF_WIDTH);
    import sorter_pkg::*;

    logic                   in_valid;
    logic [WIDTH-1:0]       in_key;
    logic                   in_last;
    logic                   out_valid;
    logic [4*WIDTH-1:0]     out_keys;
    count_t                 out_count;

    modport master (
        output in_valid, in_key, in_last,
        input  out_valid, out_keys, out_count
    );

    modport slave (
        input  in_valid, in_key, in_last,
        output out_valid, out_keys, out_count
    );

endinterface

// File: rtl/sort4_pipe_cmp_swap.sv
// Single compare-exchange element: lo/hi ordered pair, equal keys keep their order.
module cmp_swap import sorter_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    always_comb begin
        if (a > b) begin
            lo = b;
            hi = a;
        end else begin
            lo = a;
            hi = b;
        end
    end

endmodule

// File: rtl/sort4_pipe.sv
// Collects keys into groups of four (or fewer on in_last), pads with all-ones and
// sorts each group ascending through a 3-stage compare-exchange pipeline.
module sort4_pipe import sorter_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    sort4_pipe_if.slave     bus
);

    localparam logic [WIDTH-1:0] KPAD = {WIDTH{1'b1}};

    typedef logic [3:0][WIDTH-1:0] group_t;

    // Slot 3 is never stored: the fourth key always dispatches straight away.
    logic [1:0]         cnt;
    logic [WIDTH-1:0]   slot_q [0:2];
    group_t             grp;
    logic               dispatch;

    group_t             s0_k, s1_k, s2_k, out_k;
    count_t             s0_c, s1_c, s2_c, out_c;
    logic               s0_v, s1_v, s2_v, out_v;
    group_t             n1, n2, n3;

    assign dispatch = bus.in_valid && ((cnt == 2'd3) || bus.in_last);

    always_comb begin
        grp[0] = (cnt == 2'd0) ? bus.in_key : slot_q[0];
        grp[1] = (cnt == 2'd1) ? bus.in_key : ((cnt > 2'd1) ? slot_q[1] : KPAD);
        grp[2] = (cnt == 2'd2) ? bus.in_key : ((cnt > 2'd2) ? slot_q[2] : KPAD);
        grp[3] = (cnt == 2'd3) ? bus.in_key : KPAD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= 2'd0;
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            slot_q[2] <= '0;
        end else if (bus.in_valid) begin
            if (dispatch) begin
                cnt <= 2'd0;
            end else begin
                slot_q[cnt] <= bus.in_key;
                cnt         <= cnt + 2'd1;
            end
        end
    end

    cmp_swap #(.WIDTH(WIDTH)) u_s1_a (.a(s0_k[0]), .b(s0_k[1]), .lo(n1[0]), .hi(n1[1]));
    cmp_swap #(.WIDTH(WIDTH)) u_s1_b (.a(s0_k[2]), .b(s0_k[3]), .lo(n1[2]), .hi(n1[3]));
    cmp_swap #(.WIDTH(WIDTH)) u_s2_a (.a(s1_k[0]), .b(s1_k[2]), .lo(n2[0]), .hi(n2[2]));
    cmp_swap #(.WIDTH(WIDTH)) u_s2_b (.a(s1_k[1]), .b(s1_k[3]), .lo(n2[1]), .hi(n2[3]));
    cmp_swap #(.WIDTH(WIDTH)) u_s3   (.a(s2_k[1]), .b(s2_k[2]), .lo(n3[1]), .hi(n3[2]));

    assign n3[0] = s2_k[0];
    assign n3[3] = s2_k[3];

    // Data registers load only with their valid so the outputs hold between groups.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_v  <= 1'b0;  s0_k  <= '0;  s0_c  <= '0;
            s1_v  <= 1'b0;  s1_k  <= '0;  s1_c  <= '0;
            s2_v  <= 1'b0;  s2_k  <= '0;  s2_c  <= '0;
            out_v <= 1'b0;  out_k <= '0;  out_c <= '0;
        end else begin
            s0_v  <= dispatch;
            s1_v  <= s0_v;
            s2_v  <= s1_v;
            out_v <= s2_v;
            if (dispatch) begin
                s0_k <= grp;
                s0_c <= count_t'({1'b0, cnt} + 3'd1);
            end
            if (s0_v) begin
                s1_k <= n1;
                s1_c <= s0_c;
            end
            if (s1_v) begin
                s2_k <= n2;
                s2_c <= s1_c;
            end
            if (s2_v) begin
                out_k <= n3;
                out_c <= s2_c;
            end
        end
    end

    assign bus.out_valid = out_v;
    assign bus.out_keys  = out_k;
    assign bus.out_count = out_c;

endmodule

// File: tb/tb_sort4_pipe.sv
// Bench for sort4_pipe: directed and random key streams against a group-and-sort
// reference model, with a scoreboard checking contents, count, latency and hold.
module tb_sort4_pipe;
  import sorter_pkg::*;

  localparam int W = DEF_WIDTH;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sort4_pipe_if #(.WIDTH(W)) bus ();

  sort4_pipe #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // scoreboard state
  int checks = 0;
  int errors = 0;
  logic [4*W+2:0] exp_q[$];
  int exp_t_q[$];
  logic [W-1:0] coll_q[$];
  logic [4*W-1:0] last_keys = '0;
  logic [2:0] last_cnt = '0;
  logic [4*W+2:0] mon_e;
  int mon_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference model: pad the collected keys, sort ascending, pack element 0 low
  task automatic model_dispatch(input int t);
    logic [W-1:0] a[4];
    logic [W-1:0] tmp;
    logic [4*W-1:0] pk;
    int n;
    n = coll_q.size();
    for (int i = 0; i < 4; i++) a[i] = (i < n) ? coll_q[i] : {W{1'b1}};
    for (int i = 0; i < 3; i++)
      for (int j = i + 1; j < 4; j++)
        if (a[j] < a[i]) begin
          tmp = a[i]; a[i] = a[j]; a[j] = tmp;
        end
    for (int i = 0; i < 4; i++) pk[i*W +: W] = a[i];
    exp_q.push_back({3'(n), pk});
    exp_t_q.push_back(t);
    coll_q.delete();
  endtask

  // driver
  task automatic drive(input bit v, input logic [W-1:0] k, input bit l);
    @(posedge clk);
    #2;
    bus.in_valid = v;
    bus.in_key   = k;
    bus.in_last  = l;
    if (v) begin
      coll_q.push_back(k);
      if (coll_q.size() == 4 || l) model_dispatch(cyc + 4);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #2;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_key   = '0;
    bus.in_last  = 1'b0;
    exp_q.delete();
    exp_t_q.delete();
    coll_q.delete();
    last_keys = '0;
    last_cnt  = '0;
    repeat (n) @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // monitor
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
      chk("rst_out_keys", 64'(bus.out_keys), 64'(0));
      chk("rst_out_count", 64'(bus.out_count), 64'(0));
    end else if (bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 64'(bus.out_valid), 64'(0));
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = exp_t_q.pop_front();
        chk("out_keys", 64'(bus.out_keys), 64'(mon_e[4*W-1:0]));
        chk("out_count", 64'(bus.out_count), 64'(mon_e[4*W +: 3]));
        chk("latency", 64'(cyc), 64'(mon_t));
        last_keys = mon_e[4*W-1:0];
        last_cnt  = mon_e[4*W +: 3];
      end
    end else begin
      chk("hold_keys", 64'(bus.out_keys), 64'(last_keys));
      chk("hold_count", 64'(bus.out_count), 64'(last_cnt));
    end
  end

  // stimulus
  logic [W-1:0] rk;
  int pick;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_key   = '0;
    bus.in_last  = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    idle(2);

    // full group
    drive(1, 9, 0); drive(1, 3, 0); drive(1, 7, 0); drive(1, 1, 0);
    idle(6);

    // partial flush, then a fresh group from slot 0
    drive(1, 5, 0); drive(1, 2, 1);
    idle(2);

    // back-to-back single-key partials
    drive(1, 4, 1); drive(1, 6, 1); drive(1, 1, 1);
    idle(6);

    // ties
    drive(1, 3, 0); drive(1, 3, 0); drive(1, 0, 0); drive(1, 3, 0);
    idle(5);

    // gapped input
    drive(1, 8, 0); idle(2); drive(1, 2, 0); idle(1); drive(1, 6, 0); drive(1, 0, 0);
    idle(6);

    // real all-ones keys, in_last without in_valid, in_last on the fourth key
    drive(1, 8'hFF, 0); drive(1, 0, 0); drive(1, 8'hFF, 1);
    drive(1, 7, 0); drive(0, 8'h55, 1); drive(1, 5, 0); drive(1, 6, 0); drive(1, 2, 1);
    idle(6);

    // reset with a group in flight and two keys collected
    drive(1, 10, 0); drive(1, 20, 0); drive(1, 30, 0); drive(1, 40, 0);
    drive(1, 50, 0); drive(1, 60, 0);
    do_reset(3);
    drive(1, 1, 0); drive(1, 2, 0); drive(1, 3, 0); drive(1, 4, 0);
    idle(8);

    // random stream
    for (int i = 0; i < 400; i++) begin
      pick = $urandom_range(0, 3);
      case (pick)
        0: rk = {W{1'b1}};
        1: rk = W'($urandom_range(0, 3));
        default: rk = W'($urandom());
      endcase
      drive($urandom_range(0, 9) < 7, rk, $urandom_range(0, 4) == 0);
    end

    // drain with a bounded wait
    idle(1);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1);
    chk("drain_empty", 64'(exp_q.size()), 64'(0));
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
